// File: rtl/periph_bus_pkg.sv
// Shared types and constants for the peripheral bus initiator.
package periph_bus_pkg;

  localparam int BUS_AW = 32;
  localparam int BUS_DW = 32;

  typedef enum logic [2:0] {
    IDLE,
    WR_LO,
    WR_HI,
    RD_ISSUE,
    RD_WAIT,
    RESP
  } state_t;

  // 64-bit registers pair at an even/odd word address; hi selects the odd word.
  function automatic logic [BUS_AW-1:0] beat_addr(input logic [BUS_AW-1:0] addr,
                                                  input logic              hi);
    return {addr[BUS_AW-1:1], hi};
  endfunction

endpackage

// File: rtl/periph_bus_master.sv
// Peripheral bus initiator: one CPU request at a time, 32-bit beats, wide
// accesses split into low/high beats, fixed registered read latency.
module periph_bus_master
  import periph_bus_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic                req_wide,
  input  logic [BUS_AW-1:0]   req_addr,
  input  logic [2*BUS_DW-1:0] req_wdata,
  output logic                rsp_valid,
  output logic [2*BUS_DW-1:0] rsp_rdata,
  output logic [BUS_AW-1:0]   sys_w_addr,
  output logic [BUS_AW-1:0]   sys_r_addr,
  output logic [BUS_DW-1:0]   sys_w_line,
  input  logic [BUS_DW-1:0]   sys_r_line,
  output logic                sys_w,
  output logic                sys_r
);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                lat_wide;
  logic                hi_beat;
  logic [BUS_AW-1:0]   lat_addr;
  logic [2*BUS_DW-1:0] lat_wdata;
  logic [BUS_DW-1:0]   lo_data;

  assign req_ready = (state == IDLE) && rst;

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; the request latches are reset too, keeping the block free
  // of X even though they are only read after an accept.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      lat_wide   <= 1'b0;
      hi_beat    <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lo_data    <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      sys_w      <= 1'b0;
      sys_r      <= 1'b0;
      sys_w_addr <= '0;
      sys_r_addr <= '0;
      sys_w_line <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_wide  <= req_wide;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            hi_beat   <= 1'b0;
            if (req_we) begin
              state      <= WR_LO;
              sys_w      <= 1'b1;
              sys_w_addr <= req_wide ? beat_addr(req_addr, 1'b0) : req_addr;
              sys_w_line <= req_wdata[BUS_DW-1:0];
            end else begin
              state      <= RD_ISSUE;
              sys_r      <= 1'b1;
              sys_r_addr <= req_wide ? beat_addr(req_addr, 1'b0) : req_addr;
            end
          end
        end

        WR_LO: begin
          if (lat_wide) begin
            state      <= WR_HI;
            sys_w_addr <= beat_addr(lat_addr, 1'b1);
            sys_w_line <= lat_wdata[2*BUS_DW-1:BUS_DW];
          end else begin
            state      <= RESP;
            sys_w      <= 1'b0;
            sys_w_addr <= '0;
            sys_w_line <= '0;
            rsp_valid  <= 1'b1;
          end
        end

        WR_HI: begin
          state      <= RESP;
          sys_w      <= 1'b0;
          sys_w_addr <= '0;
          sys_w_line <= '0;
          rsp_valid  <= 1'b1;
        end

        RD_ISSUE: begin
          // The peripheral samples sys_r on this edge; data lands RD_LAT edges later.
          state      <= RD_WAIT;
          sys_r      <= 1'b0;
          sys_r_addr <= '0;
          cnt        <= CNT_W'(RD_LAT - 1);
        end

        RD_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (lat_wide && !hi_beat) begin
            lo_data    <= sys_r_line;
            hi_beat    <= 1'b1;
            state      <= RD_ISSUE;
            sys_r      <= 1'b1;
            sys_r_addr <= beat_addr(lat_addr, 1'b1);
          end else begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= lat_wide ? {sys_r_line, lo_data}
                                  : {{BUS_DW{1'b0}}, sys_r_line};
          end
        end

        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_periph_bus_master.sv
// Directed bench: two initiators (read latency 1 and 3) share the request
// inputs; each has its own registered read responder.
module tb_periph_bus_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, req_wide;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;

  logic        a_ready, a_rsp, a_sys_w, a_sys_r;
  logic [63:0] a_rdata;
  logic [31:0] a_waddr, a_raddr, a_wline;
  logic [31:0] a_rline = 32'h0;

  logic        b_ready, b_rsp, b_sys_w, b_sys_r;
  logic [63:0] b_rdata;
  logic [31:0] b_waddr, b_raddr, b_wline;
  logic [31:0] b_pipe [3] = '{default: 32'h0};

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  periph_bus_master #(.RD_LAT(1), .CNT_W(4)) u_lat1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(a_ready),
    .req_we(req_we), .req_wide(req_wide), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(a_rsp), .rsp_rdata(a_rdata), .sys_w_addr(a_waddr), .sys_r_addr(a_raddr),
    .sys_w_line(a_wline), .sys_r_line(a_rline), .sys_w(a_sys_w), .sys_r(a_sys_r)
  );

  periph_bus_master #(.RD_LAT(3), .CNT_W(4)) u_lat3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(b_ready),
    .req_we(req_we), .req_wide(req_wide), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(b_rsp), .rsp_rdata(b_rdata), .sys_w_addr(b_waddr), .sys_r_addr(b_raddr),
    .sys_w_line(b_wline), .sys_r_line(b_pipe[2]), .sys_w(b_sys_w), .sys_r(b_sys_r)
  );

  function automatic logic [31:0] peri_data(input logic [31:0] addr);
    case (addr)
      32'h40:  return 32'hA5A5A5A5;
      32'h80:  return 32'h00000001;
      32'h81:  return 32'h00000002;
      default: return 32'hBAD00000 | addr;
    endcase
  endfunction

  // Responders: data is only present on the bus for the cycle it is due,
  // so a capture on the wrong edge reads zero.
  always @(posedge clk) begin
    a_rline   <= a_sys_r ? peri_data(a_raddr) : 32'h0;
    b_pipe[0] <= b_sys_r ? peri_data(b_raddr) : 32'h0;
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic wide, input logic [31:0] addr,
                       input logic [63:0] wdata);
    req_we    = we;
    req_wide  = wide;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_both_idle(input string tag);
    int n = 0;
    while (!(a_ready && b_ready) && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, {63'h0, a_ready && b_ready}, 64'h1);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_a_w"},     a_sys_w, 0);
    check({tag, "_a_r"},     a_sys_r, 0);
    check({tag, "_a_waddr"}, a_waddr, 0);
    check({tag, "_a_raddr"}, a_raddr, 0);
    check({tag, "_a_wline"}, a_wline, 0);
    check({tag, "_a_rsp"},   a_rsp,   0);
    check({tag, "_a_rdata"}, a_rdata, 0);
    check({tag, "_a_ready"}, a_ready, 0);
    check({tag, "_b_w"},     b_sys_w, 0);
    check({tag, "_b_r"},     b_sys_r, 0);
    check({tag, "_b_rsp"},   b_rsp,   0);
    check({tag, "_b_ready"}, b_ready, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst       = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_wide  = 1'b1;
    req_addr  = 32'h55;
    req_wdata = '1;

    // Reset held for three edges with a request pending.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_quiet($sformatf("rst%0d", i));
    end
    req_valid = 1'b0;
    rst       = 1'b1;
    #1;
    check("rel_a_ready", a_ready, 1);
    check("rel_b_ready", b_ready, 1);

    // Narrow write.
    issue(1'b1, 1'b0, 32'h100, 64'hCAFEF00D_DEADBEEF);
    check("nw_e0_w",     a_sys_w, 1);
    check("nw_e0_addr",  a_waddr, 32'h100);
    check("nw_e0_line",  a_wline, 32'hDEADBEEF);
    check("nw_e0_r",     a_sys_r, 0);
    check("nw_e0_rsp",   a_rsp,   0);
    check("nw_e0_ready", a_ready, 0);
    tick();
    check("nw_e1_w",     a_sys_w, 0);
    check("nw_e1_addr",  a_waddr, 0);
    check("nw_e1_rsp",   a_rsp,   1);
    check("nw_e1_ready", a_ready, 0);
    check("nw_e1_b_rsp", b_rsp,   1);
    tick();
    check("nw_e2_rsp",   a_rsp,   0);
    check("nw_e2_ready", a_ready, 1);

    // Wide write: odd address still pairs at 0x200/0x201.
    issue(1'b1, 1'b1, 32'h201, 64'h11223344_55667788);
    check("ww_e0_w",    a_sys_w, 1);
    check("ww_e0_addr", a_waddr, 32'h200);
    check("ww_e0_line", a_wline, 32'h55667788);
    tick();
    check("ww_e1_w",    a_sys_w, 1);
    check("ww_e1_addr", a_waddr, 32'h201);
    check("ww_e1_line", a_wline, 32'h11223344);
    check("ww_e1_rsp",  a_rsp,   0);
    tick();
    check("ww_e2_w",    a_sys_w, 0);
    check("ww_e2_line", a_wline, 0);
    check("ww_e2_rsp",  a_rsp,   1);
    tick();
    check("ww_e3_ready", a_ready, 1);
    wait_both_idle("ww");

    // Narrow read of 0x40.
    issue(1'b0, 1'b0, 32'h40, 64'h0);
    check("nr_e0_r",    a_sys_r, 1);
    check("nr_e0_addr", a_raddr, 32'h40);
    check("nr_e0_w",    a_sys_w, 0);
    tick();
    check("nr_e1_r",    a_sys_r, 0);
    check("nr_e1_addr", a_raddr, 0);
    check("nr_e1_rsp",  a_rsp,   0);
    tick();
    check("nr_e2_rsp",   a_rsp,   1);
    check("nr_e2_rdata", a_rdata, 64'h00000000_A5A5A5A5);
    check("nr_e2_b_rsp", b_rsp,   0);
    tick();
    check("nr_e3_rsp",   a_rsp, 0);
    check("nr_e3_b_rsp", b_rsp, 0);
    tick();
    check("nr_e4_b_rsp",   b_rsp,   1);
    check("nr_e4_b_rdata", b_rdata, 64'h00000000_A5A5A5A5);
    wait_both_idle("nr");

    // Wide read of 0x80/0x81, walked edge by edge.
    issue(1'b0, 1'b1, 32'h80, 64'h0);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("wr_e%0d_b_r", k),     b_sys_r, (k == 0 || k == 4));
      check($sformatf("wr_e%0d_b_raddr", k), b_raddr, (k == 0) ? 32'h80 : (k == 4) ? 32'h81 : 32'h0);
      check($sformatf("wr_e%0d_b_rsp", k),   b_rsp,   (k == 8));
      check($sformatf("wr_e%0d_b_ovl", k),   b_sys_r & b_sys_w, 0);
      check($sformatf("wr_e%0d_a_r", k),     a_sys_r, (k == 0 || k == 2));
      check($sformatf("wr_e%0d_a_rsp", k),   a_rsp,   (k == 4));
      if (k == 4)
        check("wr_a_rdata", a_rdata, 64'h00000002_00000001);
      if (k >= 4 && k <= 7)
        check($sformatf("wr_e%0d_b_hold", k), b_rdata, 64'h00000000_A5A5A5A5);
      if (k == 8)
        check("wr_b_rdata", b_rdata, 64'h00000002_00000001);
      tick();
    end
    wait_both_idle("wr");

    // Reset while both initiators sit in RD_WAIT of a wide read.
    issue(1'b0, 1'b1, 32'h80, 64'h0);
    tick();
    rst = 1'b0;
    tick();
    check("mr_b_r",     b_sys_r, 0);
    check("mr_b_raddr", b_raddr, 0);
    check("mr_b_rsp",   b_rsp,   0);
    check("mr_b_ready", b_ready, 0);
    check("mr_a_r",     a_sys_r, 0);
    check("mr_a_rdata", a_rdata, 0);
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("mr_post%0d_a_rsp", k), a_rsp, 0);
      check($sformatf("mr_post%0d_b_rsp", k), b_rsp, 0);
    end
    check("mr_ready", {63'h0, a_ready && b_ready}, 64'h1);

    issue(1'b1, 1'b0, 32'h300, 64'h0_12345678);
    check("pw_e0_w",    b_sys_w, 1);
    check("pw_e0_addr", b_waddr, 32'h300);
    check("pw_e0_line", b_wline, 32'h12345678);
    tick();
    check("pw_e1_rsp",  b_rsp, 1);
    check("pw_e1_w",    b_sys_w, 0);
    tick();
    check("pw_e2_ready", b_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
